// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath selects and ALU op, and traps on illegal encodings or memory timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       mem_ready,
  input  logic       alu_zero,
  input  logic       alu_res0,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [4:0] alu_op,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_SYSTEM
  } cls_e;

  localparam logic [4:0] ALU_AND = 5'd0, ALU_OR = 5'd1, ALU_ADD = 5'd2, ALU_SUB = 5'd3,
                         ALU_SLL = 5'd4, ALU_SRL = 5'd5, ALU_SRA = 5'd6, ALU_XOR = 5'd7,
                         ALU_SLT = 5'd9, ALU_SLTU = 5'd10;

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d, dec_cls;
  logic [4:0]        alu_q, alu_d, dec_alu;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        cause_q, cause_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [TO_W:0]     cnt_inc;
  logic              dec_legal, to_hit, br_taken;

  function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic f7b5,
                                          input logic is_r);
    case (f3)
      3'b000:  arith_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec_legal = 1'b0;
    dec_cls   = C_SYSTEM;
    dec_alu   = ALU_ADD;
    case (opcode)
      7'b0110011: begin
        dec_cls   = C_R;
        dec_legal = (func7 == 7'b0000000) ||
                    (func7 == 7'b0100000 && (func3 == 3'b000 || func3 == 3'b101));
        dec_alu   = arith_op(func3, func7[5], 1'b1);
      end
      7'b0010011: begin
        dec_cls   = C_OPIMM;
        dec_legal = (func3 == 3'b001) ? (func7 == 7'b0000000) :
                    (func3 == 3'b101) ? (func7 == 7'b0000000 || func7 == 7'b0100000) : 1'b1;
        dec_alu   = arith_op(func3, func7[5], 1'b0);
      end
      7'b0000011: begin
        dec_cls   = C_LOAD;
        dec_legal = (func3 != 3'b011) && (func3 != 3'b110) && (func3 != 3'b111);
      end
      7'b0100011: begin
        dec_cls   = C_STORE;
        dec_legal = (func3 <= 3'b010);
      end
      7'b1100011: begin
        dec_cls   = C_BRANCH;
        dec_legal = (func3 != 3'b010) && (func3 != 3'b011);
        case (func3[2:1])
          2'b10:   dec_alu = ALU_SLT;
          2'b11:   dec_alu = ALU_SLTU;
          default: dec_alu = ALU_SUB;
        endcase
      end
      7'b1101111: begin dec_cls = C_JAL;    dec_legal = 1'b1; end
      7'b1100111: begin dec_cls = C_JALR;   dec_legal = (func3 == 3'b000); end
      7'b0110111: begin dec_cls = C_LUI;    dec_legal = 1'b1; end
      7'b0010111: begin dec_cls = C_AUIPC;  dec_legal = 1'b1; end
      7'b1110011: begin dec_cls = C_SYSTEM; dec_legal = 1'b1; end
      default:    dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (f3_q)
      3'b000:         br_taken = alu_zero;
      3'b001:         br_taken = !alu_zero;
      3'b100, 3'b110: br_taken = alu_res0;
      3'b101, 3'b111: br_taken = !alu_res0;
      default:        br_taken = 1'b0;
    endcase
  end

  // Count of cycles the current request has gone unanswered, including this one.
  assign cnt_inc = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};
  assign to_hit  = (TIMEOUT != 0) && (cnt_inc == (TO_W + 1)'(TIMEOUT));

  // Memory handshake: mem_req is a valid that stays high (with stable addr_sel/mem_we)
  // until a cycle with mem_ready=1 completes it; mem_ready is ignored when mem_req=0.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    alu_d     = alu_q;
    f3_d      = f3_q;
    cause_d   = cause_q;
    cnt_d     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_op    = 5'd0;
    alu_a_sel = 2'd0;
    alu_b_sel = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    retire    = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_op = alu_q;
      case (cls_q)
        C_OPIMM, C_LOAD, C_STORE, C_JALR: alu_b_sel = 2'd1;
        C_LUI:   begin alu_a_sel = 2'd2; alu_b_sel = 2'd1; end
        C_AUIPC: begin alu_a_sel = 2'd1; alu_b_sel = 2'd1; end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_inc[TO_W-1:0];
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          cls_d   = dec_cls;
          alu_d   = dec_alu;
          f3_d    = func3;
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            pc_sel  = br_taken ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end
          C_SYSTEM: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_inc[TO_W-1:0];
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        case (cls_q)
          C_LOAD:  wb_sel = 2'd1;
          C_JAL:   begin wb_sel = 2'd2; pc_sel = 2'd1; end
          C_JALR:  begin wb_sel = 2'd2; pc_sel = 2'd2; end
          default: ;
        endcase
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_R;
      alu_q   <= 5'd0;
      f3_q    <= 3'd0;
      cause_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      f3_q    <= f3_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level reference model predicts
// per-phase outputs and retire latency; directed cases cover trap, timeout and reset.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       mem_ready = 1'b0;
  logic       alu_zero = 1'b0;
  logic       alu_res0 = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, retire, trap;
  logic [1:0] pc_sel, alu_a_sel, alu_b_sel, wb_sel, trap_cause;
  logic [4:0] alu_op;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  localparam logic [3:0] K_R = 4'd0, K_OPIMM = 4'd1, K_LOAD = 4'd2, K_STORE = 4'd3,
                         K_BRANCH = 4'd4, K_JAL = 4'd5, K_JALR = 4'd6, K_LUI = 4'd7,
                         K_AUIPC = 4'd8, K_SYSTEM = 4'd9, K_BAD = 4'd15;

  typedef struct packed {
    logic       legal;
    logic [3:0] cls;
    logic [4:0] alu;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic       sel_known;
  } dec_t;

  multicycle_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .alu_res0(alu_res0),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_op(alu_op), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire),
    .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {mem_req, mem_we, ir_we, pc_we, reg_we, retire};
  endfunction

  function automatic logic [25:0] all_outs();
    return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_op, alu_a_sel,
            alu_b_sel, reg_we, wb_sel, retire, trap, trap_cause, state};
  endfunction

  // Reference decode straight from the instruction-set tables.
  function automatic dec_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
    logic [4:0] arith_tbl [8];
    logic [4:0] br_tbl    [8];
    dec_t d;
    arith_tbl = '{5'd2, 5'd4, 5'd9, 5'd10, 5'd7, 5'd5, 5'd1, 5'd0};
    br_tbl    = '{5'd3, 5'd3, 5'd0, 5'd0, 5'd9, 5'd9, 5'd10, 5'd10};
    d = '0;
    d.alu = 5'd2;
    d.sel_known = 1'b1;
    case (op)
      7'h33: begin
        d.cls = K_R;
        d.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        d.alu = arith_tbl[f3];
        if (f7[5] && f3 == 3'd0) d.alu = 5'd3;
        if (f7[5] && f3 == 3'd5) d.alu = 5'd6;
      end
      7'h13: begin
        d.cls = K_OPIMM;
        d.legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                  (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        d.alu = arith_tbl[f3];
        if (f7[5] && f3 == 3'd5) d.alu = 5'd6;
        d.bsel = 2'd1;
      end
      7'h03: begin d.cls = K_LOAD; d.legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; d.bsel = 2'd1; end
      7'h23: begin d.cls = K_STORE; d.legal = (f3 <= 3'd2); d.bsel = 2'd1; end
      7'h63: begin d.cls = K_BRANCH; d.legal = !(f3 inside {3'd2, 3'd3}); d.alu = br_tbl[f3]; end
      7'h6f: begin d.cls = K_JAL; d.legal = 1'b1; d.sel_known = 1'b0; end
      7'h67: begin d.cls = K_JALR; d.legal = (f3 == 3'd0); d.bsel = 2'd1; end
      7'h37: begin d.cls = K_LUI; d.legal = 1'b1; d.asel = 2'd2; d.bsel = 2'd1; end
      7'h17: begin d.cls = K_AUIPC; d.legal = 1'b1; d.asel = 2'd1; d.bsel = 2'd1; end
      7'h73: begin d.cls = K_SYSTEM; d.legal = 1'b1; d.sel_known = 1'b0; end
      default: begin d.cls = K_BAD; d.legal = 1'b0; end
    endcase
    return d;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic r0);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    return f3[0] ? !r0 : r0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 check("rst.outs", 32'(all_outs()), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle.outs", 32'(all_outs()), 32'd0);
  endtask

  // Runs one instruction from its first FETCH cycle; legal=0 means it trapped in DECODE.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw, input logic z, input logic r0,
                           output logic legal);
    dec_t e;
    int cyc;
    logic tk, is_mem, is_st, last;
    logic [1:0] exp_wb, exp_pc;
    e = ref_decode(op, f3, f7);
    legal = e.legal;
    is_mem = (e.cls == K_LOAD) || (e.cls == K_STORE);
    is_st = (e.cls == K_STORE);
    if (e.cls == K_BRANCH || e.cls == K_SYSTEM) exp_q.push_back(32'(3 + fw));
    else if (e.cls == K_LOAD) exp_q.push_back(32'(5 + fw + mw));
    else exp_q.push_back(32'(4 + fw + (is_st ? mw : 0)));
    cyc = 0;
    for (int w = 0; w <= fw; w++) begin
      @(negedge clk);
      if (w == 0) begin opcode = op; func3 = f3; func7 = f7; end
      mem_ready = (w == fw);
      #1 cyc++;
      check("fetch.state", 32'(state), 32'd1);
      check("fetch.strb", 32'(strobes()), {26'd0, 1'b1, 1'b0, (w == fw), 3'b000});
      check("fetch.addr", 32'(addr_sel), 32'd0);
    end
    @(negedge clk);
    mem_ready = 1'($urandom_range(0, 1));
    #1 cyc++;
    check("decode.state", 32'(state), 32'd2);
    check("decode.strb", 32'(strobes()), 32'd0);
    if (!e.legal) begin
      void'(exp_q.pop_back());
      @(negedge clk);
      #1 check("illegal.trap", {29'd0, state, trap, trap_cause}, {29'd6, 1'b1, 2'd1});
      check("illegal.strb", 32'(strobes()), 32'd0);
      return;
    end
    @(negedge clk);
    alu_zero = z;
    alu_res0 = r0;
    mem_ready = 1'($urandom_range(0, 1));
    #1 cyc++;
    check("exec.state", 32'(state), 32'd3);
    if (e.sel_known) begin
      check("exec.alu_op", 32'(alu_op), 32'(e.alu));
      check("exec.sel", {28'd0, alu_a_sel, alu_b_sel}, {28'd0, e.asel, e.bsel});
    end
    if (e.cls == K_BRANCH || e.cls == K_SYSTEM) begin
      tk = (e.cls == K_BRANCH) && ref_taken(f3, z, r0);
      check("exec.strb", 32'(strobes()), 32'b000101);
      check("exec.pc_sel", 32'(pc_sel), {31'd0, tk});
      check("latency", 32'(cyc), exp_q.pop_front());
      return;
    end
    check("exec.strb", 32'(strobes()), 32'd0);
    if (is_mem) begin
      for (int w = 0; w <= mw; w++) begin
        @(negedge clk);
        last = (w == mw);
        mem_ready = last;
        #1 cyc++;
        check("mem.state", 32'(state), 32'd4);
        check("mem.addr", 32'(addr_sel), 32'd1);
        check("mem.strb", 32'(strobes()), {26'd0, 1'b1, is_st, 1'b0, is_st && last, 1'b0, is_st && last});
        if (is_st && last) check("mem.pc_sel", 32'(pc_sel), 32'd0);
      end
      if (is_st) begin
        check("latency", 32'(cyc), exp_q.pop_front());
        return;
      end
    end
    @(negedge clk);
    mem_ready = 1'($urandom_range(0, 1));
    #1 cyc++;
    exp_wb = (e.cls == K_LOAD) ? 2'd1 : (e.cls == K_JAL || e.cls == K_JALR) ? 2'd2 : 2'd0;
    exp_pc = (e.cls == K_JAL) ? 2'd1 : (e.cls == K_JALR) ? 2'd2 : 2'd0;
    check("wb.state", 32'(state), 32'd5);
    check("wb.strb", 32'(strobes()), 32'b000111);
    check("wb.sel", {28'd0, wb_sel, pc_sel}, {28'd0, exp_wb, exp_pc});
    check("latency", 32'(cyc), exp_q.pop_front());
  endtask

  initial begin
    logic ok;
    logic [6:0] ops [10];
    logic [6:0] op, f7;
    int pick;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73};

    do_reset();
    run_instr(7'h33, 3'd0, 7'h20, 0, 0, 1'b0, 1'b0, ok);   // SUB
    run_instr(7'h03, 3'd2, 7'h00, 0, 3, 1'b0, 1'b0, ok);   // LW, 3 wait states
    run_instr(7'h63, 3'd1, 7'h00, 0, 0, 1'b0, 1'b0, ok);   // BNE taken
    run_instr(7'h63, 3'd1, 7'h00, 0, 0, 1'b1, 1'b0, ok);   // BNE not taken
    run_instr(7'h13, 3'd5, 7'h20, 0, 0, 1'b0, 1'b0, ok);   // SRAI
    run_instr(7'h13, 3'd5, 7'h01, 0, 0, 1'b0, 1'b0, ok);   // illegal shift
    check("illegal.seen", 32'(ok), 32'd0);
    repeat (20) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1 check("trap.hold", {24'd0, state, trap, trap_cause, mem_req, retire},
                 {24'd0, 3'd6, 1'b1, 2'd1, 1'b0, 1'b0});
    end

    // Fetch never answered: four request cycles, then bus-timeout trap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1 check("to.req", {30'd0, state == 3'd1, mem_req}, 32'd3);
    end
    repeat (3) begin
      @(negedge clk);
      #1 check("to.trap", {26'd0, state, trap, trap_cause}, {26'd0, 3'd6, 1'b1, 2'd2});
      check("to.req_low", 32'(strobes()), 32'd0);
    end

    // Reset in the middle of a store's memory phase.
    do_reset();
    @(negedge clk); opcode = 7'h23; func3 = 3'd2; func7 = 7'h00; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("st.mem", {29'd0, state == 3'd4, mem_req, mem_we}, 32'd7);
    rst = 1'b1;
    #1 check("st.rst", {27'd0, mem_req, mem_we, retire, pc_we, state == 3'd0}, 32'd1);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      pick = $urandom_range(0, 11);
      op = (pick >= 10) ? 7'($urandom_range(0, 127)) : ops[pick];
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      run_instr(op, 3'($urandom_range(0, 7)), f7, $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ok);
      if (!ok) do_reset();
    end
    check("scoreboard.empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences the shared memory port, instruction register, PC, ALU operand muxes and register-file write across FETCH/DECODE/EXEC/MEM/WB.
- Drives the 5-bit ALU operation code from the decoded instruction fields.
- Traps on illegal encodings and on memory timeout.

Parameters:
- TIMEOUT, 255: cycles mem_req may stay unanswered before a bus-error trap; 0 disables the check.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instruction register [6:0]
- func3  in  3  instruction register [14:12]
- func7  in  7  instruction register [31:25]
- mem_ready  in  1  memory completes the current request this cycle
- alu_zero  in  1  ALU result == 0
- alu_res0  in  1  ALU result bit 0 (SLT/SLTU outcome)
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  store request
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result
- ir_we  out  1  instruction register load
- pc_we  out  1  PC update
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result & ~1
- alu_op  out  5  AND=0, OR=1, ADD=2, SUB=3, SLL=4, SRL=5, SRA=6, XOR=7, SLT=9, SLTU=10
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_b_sel  out  2  0 = rs2, 1 = imm, 2 = constant 4
- reg_we  out  1  register-file write
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky: illegal instruction or bus timeout
- trap_cause  out  2  0 = none, 1 = illegal, 2 = bus timeout
- state  out  3  debug: current state encoding

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset: state=IDLE. All outputs are 0 while rst is high and while in IDLE. IDLE -> FETCH on the first clk edge after rst deasserts.
- Reset mid-access: mem_req drops asynchronously; any pending transaction is abandoned.
- FETCH: mem_req=1, addr_sel=0.
  - On mem_ready: ir_we=1 in the same cycle, -> DECODE.
  - Otherwise stay in FETCH.
- DECODE: check legality.
  - Illegal -> TRAP, trap_cause=1.
  - Legal -> latch op class and alu_op into registers, -> EXEC.
  - EXEC/MEM/WB outputs are driven only from these registered values.
- Legal encodings:
  - R: opcode 0110011; func7 is 0000000, or 0100000 only with func3 000/101.
  - OP-IMM: opcode 0010011; func3 001 requires func7=0000000; func3 101 requires func7 in {0000000, 0100000}.
  - LOAD: opcode 0000011; func3 in {000, 001, 010, 100, 101}.
  - STORE: opcode 0100011; func3 <= 010.
  - BRANCH: opcode 1100011; func3 not 010/011.
  - JAL 1101111, JALR 1100111 (func3=000), LUI 0110111, AUIPC 0010111, SYSTEM 1110011 (executed as NOP).
- alu_op mapping:
  - R/OP-IMM by func3: 000 -> ADD (SUB when R-type and func7[5]=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRL (SRA when func7[5]=1); 110 OR; 111 AND.
  - LOAD/STORE/JALR/LUI/AUIPC -> ADD.
  - Branch: 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU.
- Operand selects in EXEC:
  - R and branch: a=rs1, b=rs2. OP-IMM, LOAD, STORE, JALR: a=rs1, b=imm.
  - LUI: a=zero, b=imm. AUIPC: a=PC, b=imm.
- EXEC transitions:
  - R, OP-IMM, LUI, AUIPC, JAL, JALR -> WB.
  - LOAD, STORE -> MEM.
  - BRANCH: pc_we=1, retire=1, -> FETCH. pc_sel=1 when taken, else 0. Taken conditions: BEQ alu_zero; BNE !alu_zero; BLT/BLTU alu_res0; BGE/BGEU !alu_res0.
  - SYSTEM: pc_we=1, pc_sel=0, retire=1, -> FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE.
  - Wait for mem_ready.
  - LOAD -> WB.
  - STORE -> pc_we=1, pc_sel=0, retire=1, -> FETCH.
- WB: reg_we=1, pc_we=1, retire=1, -> FETCH.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_sel: 1 for JAL, 2 for JALR, else 0.
- mem_ready is ignored whenever mem_req=0.
- Timeout: counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && !mem_ready. When TIMEOUT != 0 and the count reaches TIMEOUT -> TRAP, trap_cause=2, mem_req drops the next cycle.
- TRAP: absorbing. Only rst leaves it. All strobes are 0; trap=1 and trap_cause hold.
- Latency with zero-wait memory: branch/SYSTEM 3 cycles; R/I/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5.

Test Plan:
- rst high 3 cycles, then low; R-type SUB (opcode 0110011, func3 000, func7 0100000), mem_ready=1 -> IDLE, FETCH (ir_we=1), DECODE, EXEC (alu_op=3, a_sel=0, b_sel=0), WB (reg_we=1, wb_sel=0, pc_sel=0, retire=1).
- LOAD func3=010 with mem_ready delayed 3 cycles in MEM -> mem_req=1, addr_sel=1 held 4 cycles; then WB with wb_sel=1; retire is the only pulse.
- BNE with alu_zero=0 -> EXEC pc_we=1, pc_sel=1, retire=1, next state FETCH. Repeat with alu_zero=1 -> pc_sel=0.
- SRAI (opcode 0010011, func3 101, func7 0100000) -> alu_op=6, b_sel=1. Same opcode with func7=0000001 -> TRAP, trap=1, trap_cause=1; state stays 6 for 20 cycles.
- TIMEOUT=4, mem_ready held 0 in FETCH -> trap_cause=2 after 4 request cycles, mem_req=0 thereafter.
- rst asserted mid-MEM store -> mem_req and mem_we fall immediately, state=0, no retire.
